// File: rtl/cmd_uart_link_if.sv
// Bundle of the command-link signals between the UART endpoint and its neighbours.
// The slave modport is the endpoint itself. The master modport is the pin/command-processor side.
// RX and TX keep their pin names because they map straight onto the board-level serial lines.
interface cmd_uart_link_if;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    modport slave (
        input  RX, clr_cmd_rdy, resp, trmt,
        output TX, cmd, cmd_rdy, tx_done
    );

    modport master (
        output RX, clr_cmd_rdy, resp, trmt,
        input  TX, cmd, cmd_rdy, tx_done
    );
endinterface

// File: rtl/cmd_uart_link.sv
// Robot-side UART endpoint: assembles two RX bytes (high first) into a 16-bit command and serializes response bytes.
// Latency: cmd_rdy rises one clk after the low byte's stop-bit sample; TX start bit appears one clk after trmt.
// No backpressure: cmd_rdy is a sticky flag cleared by clr_cmd_rdy; trmt while busy is dropped. Option macro: BYTE_TIMEOUT_EN.
module cmd_uart_link #(
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    cmd_uart_link_if.slave  bus
);

    localparam logic [11:0] HALF_BIT    = 12'(BAUD_DIV / 2);
    localparam logic [11:0] FULL_BIT_M1 = 12'(BAUD_DIV - 1);
    localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_CLKS - 1);

    typedef enum logic {R_IDLE, R_RECV} rx_state_t;
    typedef enum logic {F_HI, F_LO}     frm_state_t;
    typedef enum logic {T_IDLE, T_SEND} tx_state_t;

    rx_state_t   rx_state;
    frm_state_t  frm_state;
    tx_state_t   tx_state;

    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic        start_edge;

    logic [11:0] rx_cnt;
    logic [3:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic [7:0]  hi_byte;

    logic [11:0] tx_cnt;
    logic [3:0]  tx_idx;
    logic [8:0]  tx_shift;

`ifdef BYTE_TIMEOUT_EN
    logic [31:0] to_cnt;
`else
    // The timeout limit has no consumer when the byte timeout is compiled out.
    logic        unused_timeout_cfg;
    assign unused_timeout_cfg = ^TO_LAST;
`endif

    // Two-flop synchronizer on the asynchronous RX pin plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;

    // Receiver, byte framer and command register; a set of cmd_rdy is written last so it beats any clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= R_IDLE;
            frm_state   <= F_HI;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_shift    <= '0;
            hi_byte     <= '0;
            bus.cmd     <= '0;
            bus.cmd_rdy <= 1'b0;
`ifdef BYTE_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            if (bus.clr_cmd_rdy) begin
                bus.cmd_rdy <= 1'b0;
            end

            case (rx_state)
                R_IDLE: begin
                    if (start_edge) begin
                        rx_state <= R_RECV;
                        rx_cnt   <= HALF_BIT;
                        rx_idx   <= '0;
                        // A new high byte starting means the consumer has missed its window for the old command flag.
                        if (frm_state == F_HI) begin
                            bus.cmd_rdy <= 1'b0;
                        end
                    end
                end
                R_RECV: begin
                    if (rx_cnt != 12'd0) begin
                        rx_cnt <= rx_cnt - 12'd1;
                    end else begin
                        rx_cnt <= FULL_BIT_M1;
                        rx_idx <= rx_idx + 4'd1;
                        if (rx_idx >= 4'd1 && rx_idx <= 4'd8) begin
                            rx_shift <= {rx_sync, rx_shift[7:1]};
                        end
                        if (rx_idx == 4'd9) begin
                            rx_state <= R_IDLE;
                            if (!rx_sync) begin
                                // Bad stop bit: drop the byte and resynchronise on a fresh high byte.
                                frm_state <= F_HI;
                            end else if (frm_state == F_HI) begin
                                hi_byte   <= rx_shift;
                                frm_state <= F_LO;
`ifdef BYTE_TIMEOUT_EN
                                to_cnt    <= '0;
`endif
                            end else begin
                                bus.cmd     <= {hi_byte, rx_shift};
                                bus.cmd_rdy <= 1'b1;
                                frm_state   <= F_HI;
                            end
                        end
                    end
                end
                default: rx_state <= R_IDLE;
            endcase

`ifdef BYTE_TIMEOUT_EN
            // Inter-byte timer only runs while waiting for the low byte's start edge.
            if (frm_state == F_LO && rx_state == R_IDLE && !start_edge) begin
                if (to_cnt == TO_LAST) begin
                    frm_state <= F_HI;
                end else begin
                    to_cnt <= to_cnt + 32'd1;
                end
            end
`endif
        end
    end

    // Transmitter: registered TX, each bit held BAUD_DIV clocks, requests while busy are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= T_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_shift    <= '1;
            bus.TX      <= 1'b1;
            bus.tx_done <= 1'b0;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (bus.trmt) begin
                        tx_shift    <= {1'b1, bus.resp};
                        bus.TX      <= 1'b0;
                        bus.tx_done <= 1'b0;
                        tx_cnt      <= FULL_BIT_M1;
                        tx_idx      <= '0;
                        tx_state    <= T_SEND;
                    end
                end
                T_SEND: begin
                    if (tx_cnt != 12'd0) begin
                        tx_cnt <= tx_cnt - 12'd1;
                    end else if (tx_idx == 4'd9) begin
                        tx_state    <= T_IDLE;
                        bus.TX      <= 1'b1;
                        bus.tx_done <= 1'b1;
                    end else begin
                        bus.TX   <= tx_shift[0];
                        tx_shift <= {1'b1, tx_shift[8:1]};
                        tx_idx   <= tx_idx + 4'd1;
                        tx_cnt   <= FULL_BIT_M1;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_uart_link.sv
// Directed bench for cmd_uart_link with BAUD_DIV=16 and TIMEOUT_CLKS=500.
// A byte-level model predicts cmd/cmd_rdy and a frame-timeline model predicts TX/tx_done every cycle.
// Hand-computed literals pin the model at the interesting points.
module tb_cmd_uart_link;

    localparam int BAUD    = 16;
    localparam int TO_CLKS = 500;

    logic clk;
    logic rst;
    cmd_uart_link_if bus ();

    cmd_uart_link #(.BAUD_DIV(BAUD), .TIMEOUT_CLKS(TO_CLKS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [15:0] m_cmd;
    logic        m_rdy;
    logic [7:0]  m_hi;
    bit          m_have_hi;
    int          tx_start = -1;
    logic [9:0]  tx_frame;
    bit          started = 0;
    bit          rx_win = 0;
    logic        prev_rdy = 1'b0;
    int          rise_cnt = 0;
    int          rise_cyc = 0;
    int          last_d = -1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic exp_tx(input int c);
        int k;
        k = c - tx_start;
        if (tx_start >= 0 && k >= 0 && k < 10 * BAUD) return tx_frame[k / BAUD];
        return 1'b1;
    endfunction

    function automatic logic exp_done(input int c);
        if (tx_start < 0) return 1'b0;
        return (c - tx_start >= 10 * BAUD);
    endfunction

    task automatic model_reset();
        m_cmd     = 16'h0000;
        m_rdy     = 1'b0;
        m_have_hi = 0;
        tx_start  = -1;
    endtask

    // Called on the negedge before the edge that samples trmt.
    task automatic model_trmt(input logic [7:0] b);
        if (tx_start < 0 || cyc + 1 > tx_start + 10 * BAUD) begin
            tx_start = cyc + 1;
            tx_frame = {1'b1, b, 1'b0};
        end
    endtask

    // Per-cycle comparison against the model.
    always begin
        @(posedge clk);
        #2;
        if (started) begin
            chk("tx", {15'd0, bus.TX}, {15'd0, exp_tx(cyc)});
            chk("tx_done", {15'd0, bus.tx_done}, {15'd0, exp_done(cyc)});
            if (!rx_win) begin
                chk("cmd", bus.cmd, m_cmd);
                chk("cmd_rdy", {15'd0, bus.cmd_rdy}, {15'd0, m_rdy});
            end
            if (bus.cmd_rdy === 1'b1 && prev_rdy !== 1'b1) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
            prev_rdy = bus.cmd_rdy;
        end
    end

    task automatic idle(input int n);
`ifdef BYTE_TIMEOUT_EN
        if (m_have_hi && n >= TO_CLKS) m_have_hi = 0;
`endif
        bus.RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one UART frame; clr_at/rst_at give the bit-time offset for a clr or reset pulse (-1 = none).
    task automatic send_byte(input logic [7:0] b, input bit stop, input int clr_at, input int rst_at);
        logic [9:0] fr;
        bit hi_byte;
        bit aborted;
        int s;
        int r0;
        fr      = {stop, b, 1'b0};
        hi_byte = !m_have_hi;
        aborted = 0;
        s       = cyc;
        r0      = rise_cnt;
        for (int i = 0; i < 10 * BAUD; i++) begin
            if (rst_at >= 0 && i == rst_at + 1) begin
                chk("rst_tx", {15'd0, bus.TX}, 16'd1);
                chk("rst_cmd", bus.cmd, 16'h0000);
                chk("rst_cmd_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
                chk("rst_tx_done", {15'd0, bus.tx_done}, 16'd0);
            end
            rx_win = !aborted && ((i < BAUD) || (i >= 9 * BAUD));
            if (i == BAUD && hi_byte && !aborted) m_rdy = 1'b0;
            bus.RX = aborted ? 1'b1 : fr[i / BAUD];
            bus.clr_cmd_rdy = (i == clr_at);
            if (i == rst_at) begin
                rst     = 1'b1;
                bus.RX  = 1'b1;
                aborted = 1;
                rx_win  = 0;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            @(negedge clk);
        end
        bus.clr_cmd_rdy = 1'b0;
        rst = 1'b0;
        if (!aborted) begin
            if (!stop) begin
                m_have_hi = 0;
            end else if (hi_byte) begin
                m_hi      = b;
                m_have_hi = 1;
            end else begin
                m_cmd     = {m_hi, b};
                m_rdy     = 1'b1;
                m_have_hi = 0;
            end
        end
        if (rise_cnt != r0) last_d = rise_cyc - s - 1;
        rx_win = 0;
        idle(4);
    endtask

    task automatic clr_pulse();
        bus.clr_cmd_rdy = 1'b1;
        m_rdy = 1'b0;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
    endtask

    task automatic trmt_pulse(input logic [7:0] b);
        bus.resp = b;
        bus.trmt = 1'b1;
        model_trmt(b);
        @(negedge clk);
        bus.trmt = 1'b0;
    endtask

    initial begin
        logic [9:0]  a5_bits;
        logic [15:0] exp_to;
        int          r0;

        a5_bits = 10'b1101001010;   // 0xA5 frame, index 0 = start bit
`ifdef BYTE_TIMEOUT_EN
        exp_to = 16'h1234;
`else
        exp_to = 16'h4012;
`endif
        rst = 1'b1;
        bus.RX = 1'b1;
        bus.clr_cmd_rdy = 1'b0;
        bus.resp = 8'h00;
        bus.trmt = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        started = 1;
        chk("reset_tx", {15'd0, bus.TX}, 16'd1);
        chk("reset_cmd", bus.cmd, 16'h0000);
        chk("reset_cmd_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
        chk("reset_tx_done", {15'd0, bus.tx_done}, 16'd0);
        idle(5);

        // Calibrate command 0x2000
        r0 = rise_cnt;
        send_byte(8'h20, 1'b1, -1, -1);
        send_byte(8'h00, 1'b1, -1, -1);
        chk("cal_cmd", bus.cmd, 16'h2000);
        chk("cal_latency_window", {15'd0, (last_d >= 9 * BAUD + 2) && (last_d <= 10 * BAUD - 1)}, 16'd1);
        idle(40);
        chk("cal_rdy_held", {15'd0, bus.cmd_rdy}, 16'd1);
        chk("cal_rise_once", 16'(rise_cnt - r0), 16'd1);
        clr_pulse();
        chk("cal_rdy_cleared", {15'd0, bus.cmd_rdy}, 16'd0);

        // Move command 0x4004, clear coincident with the set edge
        r0 = rise_cnt;
        send_byte(8'h40, 1'b1, -1, -1);
        send_byte(8'h04, 1'b1, last_d, -1);
        chk("move_cmd", bus.cmd, 16'h4004);
        chk("move_set_wins", {15'd0, bus.cmd_rdy}, 16'd1);
        chk("move_rise_once", 16'(rise_cnt - r0), 16'd1);

        // Response 0xA5 with an ignored second trmt
        trmt_pulse(8'hA5);
        for (int j = 0; j < 10 * BAUD + 10; j++) begin
            if (j % BAUD == BAUD / 2 && j < 10 * BAUD)
                chk("resp_bit", {15'd0, bus.TX}, {15'd0, a5_bits[j / BAUD]});
            if (j == 10 * BAUD - 1) chk("resp_done_low", {15'd0, bus.tx_done}, 16'd0);
            if (j == 10 * BAUD)     chk("resp_done_high", {15'd0, bus.tx_done}, 16'd1);
            bus.trmt = 1'b0;
            if (j == 49) begin
                bus.resp = 8'h3C;
                bus.trmt = 1'b1;
                model_trmt(8'h3C);
            end
            @(negedge clk);
        end
        bus.trmt = 1'b0;

        // Framing error then 0x1234
        r0 = rise_cnt;
        send_byte(8'h40, 1'b0, -1, -1);
        chk("frm_no_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
        chk("frm_cmd_kept", bus.cmd, 16'h4004);
        chk("frm_no_rise", 16'(rise_cnt - r0), 16'd0);
        send_byte(8'h12, 1'b1, -1, -1);
        send_byte(8'h34, 1'b1, -1, -1);
        chk("frm_cmd", bus.cmd, 16'h1234);
        chk("frm_rdy", {15'd0, bus.cmd_rdy}, 16'd1);

        // Inter-byte timeout
        send_byte(8'h40, 1'b1, -1, -1);
        idle(600);
        send_byte(8'h12, 1'b1, -1, -1);
        send_byte(8'h34, 1'b1, -1, -1);
        chk("timeout_cmd", bus.cmd, exp_to);

        // Reset during RX data bit 3 and during a TX frame, then a clean 0x55AA
        trmt_pulse(8'h00);
        send_byte(8'h55, 1'b1, -1, BAUD + 3 * BAUD + BAUD / 2);
        idle(10);
        send_byte(8'h55, 1'b1, -1, -1);
        send_byte(8'hAA, 1'b1, -1, -1);
        chk("post_rst_cmd", bus.cmd, 16'h55AA);
        chk("post_rst_rdy", {15'd0, bus.cmd_rdy}, 16'd1);

        idle(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_uart_link.md
Name: cmd_uart_link

Overview:
Robot-side endpoint of the remote command link. It receives two UART bytes from the remote controller, high byte first, and assembles them into one 16-bit command. It also serializes 8-bit response bytes back to the remote, for example the 0xA5 positive acknowledge. It sits between the RX/TX pins of KnightsTour and the command processor, and pairs with the remote-side RemoteComm.

Parameters:
- BAUD_DIV, 2604: clocks per bit (50 MHz / 19200 baud). Legal range 8..4095.
- TIMEOUT_CLKS, 1000000: maximum clocks between high and low byte. Used only with BYTE_TIMEOUT_EN.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset. Synchronous, active-high.
- RX, input, 1: serial in from the remote. Asynchronous, idles high.
- TX, output, 1: serial out to the remote. Idles high.
- cmd, output, 16: last fully assembled command.
- cmd_rdy, output, 1: a new command is valid.
- clr_cmd_rdy, input, 1: consumer acknowledges cmd.
- resp, input, 8: response byte to send.
- trmt, input, 1: one-cycle request to transmit resp.
- tx_done, output, 1: the last response has been fully sent.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high. Every flop resets on a clk edge with rst=1.
- Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, tx_done=0.
- RX synchronizer and receive states:
  - RX passes through a 2-flop synchronizer. Both flops reset to 1.
  - Receiver FSM states: R_IDLE, R_RECV.
  - In R_IDLE, a synchronized high-to-low edge enters R_RECV. The bit counter loads BAUD_DIV/2 so the start bit is sampled at mid-bit; after that, samples are taken every BAUD_DIV clocks.
  - 10 samples are taken: start, 8 data bits LSB first, stop.
  - After the stop-bit sample the FSM returns to R_IDLE. It can detect a new start edge in the very next cycle.
- Framing error:
  - A stop-bit sample of 0 discards the byte.
  - The framer returns to expecting a high byte.
  - cmd and cmd_rdy are unchanged.
- Command assembly, framer states F_HI and F_LO:
  - A good byte in F_HI latches the internal high register and moves to F_LO.
  - A good byte in F_LO loads cmd={high,byte} and sets cmd_rdy in the cycle after the stop-bit sample. The framer returns to F_HI.
  - cmd holds its value until the next complete command.
- cmd_rdy clearing and priority:
  - cmd_rdy clears on clr_cmd_rdy=1.
  - cmd_rdy also clears on start-bit detection of the next high byte.
  - If a set and a clear occur in the same cycle, the set wins.
- Transmitter:
  - FSM states: T_IDLE, T_SEND.
  - trmt=1 in T_IDLE latches the 10-bit frame {1,resp,0}, clears tx_done and enters T_SEND.
  - TX drives the start bit in the cycle after trmt. Each bit is held exactly BAUD_DIV clocks, LSB first.
  - After the stop bit's BAUD_DIV clocks the FSM returns to T_IDLE, TX=1, and tx_done is set.
  - tx_done stays high until the next accepted trmt.
  - trmt in T_SEND is ignored. The frame in flight is not corrupted.
- Full duplex: RX and TX operate independently and concurrently.
- Reset mid-frame: both FSMs abort to idle, the framer returns to F_HI, and outputs take their reset values in the same edge.

Optional Feature:
- Macro: BYTE_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while the framer is in F_LO.
  - When it reaches TIMEOUT_CLKS before the low byte's start edge, the held high byte is discarded and the framer returns to F_HI. cmd and cmd_rdy are unaffected.
  - The counter clears on entry to F_LO and on reset.
- Without the macro: no counter is present. The framer waits in F_LO indefinitely.

Test Plan:
- Calibrate command: BAUD_DIV=16; drive bytes 0x20 then 0x00 on RX -> cmd=16'h2000. cmd_rdy rises exactly once, 1 clk after the second stop-bit sample, and stays high until clr_cmd_rdy.
- Move command: send 0x40 then 0x04 -> cmd=16'h4004. Pulse clr_cmd_rdy and cmd_rdy at the same time as the set edge -> cmd_rdy=1 (set wins).
- Response: resp=0xA5, trmt pulse -> TX shows 0,1,0,1,0,0,1,0,1,1, each 16 clks. tx_done=1 after 160 clks. A second trmt at clk 50 is ignored and the frame is intact.
- Framing error: send byte 0x40 with stop=0, then 0x12, 0x34 -> cmd=16'h1234, with no spurious cmd_rdy after the bad frame.
- Reset mid-frame: assert rst during data bit 3 of an RX frame and during a TX frame -> next clk shows TX=1, cmd_rdy=0, tx_done=0, cmd=0. A following clean 0x55AA is received correctly.
- Timeout (with BYTE_TIMEOUT_EN, TIMEOUT_CLKS=500): send 0x40, idle 600 clks, then 0x12, 0x34 -> cmd=16'h1234. Without the macro, the same stimulus gives cmd=16'h4012.
